// File: rtl/spi_xip_ctrl_apb.sv
// APB front end for the spi_top Wishbone SPI master. Passes register accesses through,
// turns flash-window reads into an execute-in-place read sequence, and keeps the last
// flash word in a one-entry cache.
module spi_xip_ctrl_apb #(
  parameter logic [31:0] FLASH_BASE = 32'h3000_0000,
  parameter logic [31:0] FLASH_END  = 32'h3fff_ffff,
  parameter logic [31:0] SPI_BASE   = 32'h1000_1000,
  parameter logic [31:0] SPI_END    = 32'h1000_1fff,
  parameter int unsigned SS_IDX     = 0,
  parameter logic [15:0] DIVIDER    = 16'd1,
  parameter logic [7:0]  READ_CMD   = 8'h03,
  parameter bit          BYTE_SWAP  = 1'b1,
  parameter bit          CACHE_EN   = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] in_paddr,
  input  logic        in_psel,
  input  logic        in_penable,
  input  logic        in_pwrite,
  input  logic [31:0] in_pwdata,
  input  logic [3:0]  in_pstrb,
  output logic        in_pready,
  output logic [31:0] in_prdata,
  output logic        in_pslverr,
  output logic [4:0]  wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  typedef enum logic [3:0] {
    StIdle, StPass, StErr, StHit, StWseq, StPoll, StRdrx, StSsoff, StResp
  } state_e;

  // GO_BSY | Tx_NEG | CHAR_LEN=64
  localparam logic [31:0] CtrlGo = 32'h0000_0540;
  localparam logic [31:0] SsMask = 32'h1 << SS_IDX;

  state_e      state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic        gap_q, gap_d;
  logic [25:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        err_q, err_d;
  logic        cvld_q, cvld_d;
  logic [25:0] ctag_q, ctag_d;
  logic [31:0] cdat_q, cdat_d;

  logic        int_acc, int_we, int_done;
  logic [4:0]  int_adr;
  logic [31:0] int_dat, rx_sw;
  logic        hit_spi, hit_flash;

  assign hit_spi   = (in_paddr >= SPI_BASE) && (in_paddr <= SPI_END);
  assign hit_flash = (in_paddr >= FLASH_BASE) && (in_paddr <= FLASH_END);
  assign rx_sw     = BYTE_SWAP ? {wb_dat_i[7:0], wb_dat_i[15:8], wb_dat_i[23:16], wb_dat_i[31:24]}
                               : wb_dat_i;
  // An internal transfer completes on ack or err; gap_q keeps stb low for one cycle after.
  assign int_done  = int_acc && !gap_q && (wb_ack_i || wb_err_i);

  // Decode the internal Wishbone access implied by the current state/step.
  always_comb begin
    int_acc = 1'b0;
    int_we  = 1'b0;
    int_adr = 5'h00;
    int_dat = 32'h0;
    unique case (state_q)
      StWseq: begin
        int_acc = 1'b1;
        int_we  = 1'b1;
        unique case (step_q)
          3'd0:    begin int_adr = 5'h00; int_dat = 32'h0; end
          3'd1:    begin int_adr = 5'h04; int_dat = {READ_CMD, addr_q[21:0], 2'b00}; end
          3'd2:    begin int_adr = 5'h14; int_dat = {16'h0, DIVIDER}; end
          3'd3:    begin int_adr = 5'h18; int_dat = SsMask; end
          default: begin int_adr = 5'h10; int_dat = CtrlGo; end
        endcase
      end
      StPoll:  begin int_acc = 1'b1; int_adr = 5'h10; end
      StRdrx:  begin int_acc = 1'b1; int_adr = 5'h00; end
      StSsoff: begin int_acc = 1'b1; int_we = 1'b1; int_adr = 5'h18; end
      default: ;
    endcase
  end

  // Next-state, cache update and output decode.
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    gap_d      = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    err_d      = err_q;
    cvld_d     = cvld_q;
    ctag_d     = ctag_q;
    cdat_d     = cdat_q;
    in_pready  = 1'b0;
    in_prdata  = 32'h0;
    in_pslverr = 1'b0;
    wb_adr_o   = int_adr;
    wb_dat_o   = int_dat;
    wb_sel_o   = int_acc ? 4'hf : 4'h0;
    wb_we_o    = int_acc && int_we && !gap_q;
    wb_stb_o   = int_acc && !gap_q;
    wb_cyc_o   = int_acc && !gap_q;
    if (int_done) gap_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        wb_adr_o = 5'h00;
        wb_dat_o = 32'h0;
        if (in_psel && in_penable) begin
          if (hit_spi) begin
            state_d = StPass;
            if (in_pwrite) cvld_d = 1'b0;
          end else if (hit_flash && !in_pwrite) begin
            addr_d = in_paddr[27:2];
            if (CACHE_EN && cvld_q && (ctag_q == in_paddr[27:2])) begin
              state_d = StHit;
            end else begin
              state_d = StWseq;
              step_d  = 3'd0;
              err_d   = 1'b0;
            end
          end else begin
            state_d = StErr;
          end
        end
      end
      StPass: begin
        wb_adr_o = in_paddr[4:0];
        wb_dat_o = in_pwdata;
        wb_sel_o = in_pstrb;
        wb_we_o  = in_pwrite;
        wb_stb_o = 1'b1;
        wb_cyc_o = 1'b1;
        if (wb_ack_i || wb_err_i) begin
          in_pready  = 1'b1;
          in_prdata  = wb_dat_i;
          in_pslverr = wb_err_i;
          state_d    = StIdle;
        end
      end
      StErr: begin
        in_pready  = 1'b1;
        in_pslverr = 1'b1;
        state_d    = StIdle;
      end
      StHit: begin
        in_pready = 1'b1;
        in_prdata = cdat_q;
        state_d   = StIdle;
      end
      StWseq: if (int_done) begin
        if (wb_err_i) begin
          err_d   = 1'b1;
          state_d = StSsoff;
        end else if (step_q == 3'd4) begin
          state_d = StPoll;
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      StPoll: if (int_done) begin
        if (wb_err_i) begin
          err_d   = 1'b1;
          state_d = StSsoff;
        end else if (!wb_dat_i[8]) begin
          state_d = StRdrx;
        end
      end
      StRdrx: if (int_done) begin
        if (wb_err_i) err_d = 1'b1;
        else          data_d = rx_sw;
        state_d = StSsoff;
      end
      StSsoff: if (int_done) begin
        if (wb_err_i) err_d = 1'b1;
        state_d = StResp;
      end
      StResp: begin
        in_pready  = 1'b1;
        in_pslverr = err_q;
        in_prdata  = err_q ? 32'h0 : data_q;
        if (!err_q && CACHE_EN) begin
          cvld_d = 1'b1;
          ctag_d = addr_q;
          cdat_d = data_q;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      step_q  <= 3'd0;
      gap_q   <= 1'b0;
      addr_q  <= 26'h0;
      data_q  <= 32'h0;
      err_q   <= 1'b0;
      cvld_q  <= 1'b0;
      ctag_q  <= 26'h0;
      cdat_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      gap_q   <= gap_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cvld_q  <= cvld_d;
      ctag_q  <= ctag_d;
      cdat_q  <= cdat_d;
    end
  end

endmodule

// File: tb/tb_spi_xip_ctrl_apb.sv
// Directed bench for spi_xip_ctrl_apb with a small behavioural spi_top register model.
module tb_spi_xip_ctrl_apb;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] in_paddr = '0;
  logic        in_psel = 1'b0;
  logic        in_penable = 1'b0;
  logic        in_pwrite = 1'b0;
  logic [31:0] in_pwdata = '0;
  logic [3:0]  in_pstrb = '0;
  logic        in_pready;
  logic [31:0] in_prdata;
  logic        in_pslverr;
  logic [4:0]  wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_stb_o, wb_cyc_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i, wb_err_i;

  spi_xip_ctrl_apb dut (
    .clock(clock), .reset_n(reset_n),
    .in_paddr(in_paddr), .in_psel(in_psel), .in_penable(in_penable), .in_pwrite(in_pwrite),
    .in_pwdata(in_pwdata), .in_pstrb(in_pstrb), .in_pready(in_pready), .in_prdata(in_prdata),
    .in_pslverr(in_pslverr), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  always #5 clock = ~clock;

  // spi_top model state
  logic [31:0] tx0, tx1, divr, ssr, ctrl, rx0, last_tx0, last_tx1;
  int          busy_cnt, go_cnt, wcnt, stb_cycles;
  logic [4:0]  wlog_adr [64];
  logic [31:0] wlog_dat [64];
  logic        err_poll_en = 1'b0;

  // Flash contents as seen on MISO, first byte in the MSBs.
  function automatic logic [31:0] flash_rx(input logic [23:0] a);
    if (a == 24'h000010) return 32'hAABBCCDD;
    return {a[7:0], 8'h5A, a[15:8], 8'hC3};
  endfunction

  // Registered single-cycle ack; a GO write captures the shifted frame and makes the core busy.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wb_ack_i <= 1'b0; wb_err_i <= 1'b0; wb_dat_i <= '0;
      tx0 <= '0; tx1 <= '0; divr <= '0; ssr <= '0; ctrl <= '0; rx0 <= '0;
      busy_cnt <= 0;
    end else begin
      wb_ack_i <= 1'b0;
      wb_err_i <= 1'b0;
      if (wb_stb_o && wb_cyc_o) stb_cycles <= stb_cycles + 1;
      if (wb_stb_o && wb_cyc_o && !wb_ack_i && !wb_err_i) begin
        wb_ack_i <= 1'b1;
        if (wb_we_o) begin
          wlog_adr[wcnt[5:0]] <= wb_adr_o;
          wlog_dat[wcnt[5:0]] <= wb_dat_o;
          wcnt <= wcnt + 1;
          case (wb_adr_o)
            5'h00: tx0 <= wb_dat_o;
            5'h04: tx1 <= wb_dat_o;
            5'h14: divr <= wb_dat_o;
            5'h18: ssr <= wb_dat_o;
            5'h10: begin
              ctrl <= wb_dat_o;
              if (wb_dat_o[8]) begin
                go_cnt   <= go_cnt + 1;
                last_tx0 <= tx0;
                last_tx1 <= tx1;
                busy_cnt <= 3;
                rx0      <= flash_rx(tx1[23:0]);
              end
            end
            default: ;
          endcase
        end else begin
          case (wb_adr_o)
            5'h00: wb_dat_i <= rx0;
            5'h10: begin
              wb_dat_i <= {ctrl[31:9], busy_cnt > 0, ctrl[7:0]};
              if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
              if (err_poll_en) wb_err_i <= 1'b1;
            end
            5'h14: wb_dat_i <= divr;
            5'h18: wb_dat_i <= ssr;
            default: wb_dat_i <= 32'h0;
          endcase
        end
      end
    end
  end

  initial begin
    go_cnt = 0; wcnt = 0; stb_cycles = 0;
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apb(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                     output logic [31:0] rd, output logic er, output int lat);
    @(posedge clock); #1;
    in_psel = 1'b1; in_penable = 1'b0; in_pwrite = wr; in_paddr = a; in_pwdata = wd;
    in_pstrb = 4'hf;
    @(posedge clock); #1;
    in_penable = 1'b1;
    lat = 0;
    do begin
      @(posedge clock); #1;
      lat++;
    end while (!in_pready && lat < 300);
    rd = in_prdata;
    er = in_pslverr;
    chk("apb_pready_seen", {31'h0, in_pready}, 32'h1);
    @(posedge clock); #1;
    in_psel = 1'b0; in_penable = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat, g0, w0, s0, n;
  logic [4:0]  exp_adr [6];
  logic [31:0] exp_dat [6];

  initial begin
    exp_adr = '{5'h00, 5'h04, 5'h14, 5'h18, 5'h10, 5'h18};
    exp_dat = '{32'h0, 32'h0300_0010, 32'h1, 32'h1, 32'h540, 32'h0};
    #12;
    chk("reset_outputs",
        {in_pready, in_pslverr, wb_we_o, wb_stb_o, wb_cyc_o, wb_sel_o, wb_adr_o}, 32'h0);
    chk("reset_prdata", in_prdata, 32'h0);
    chk("reset_wbdat", wb_dat_o, 32'h0);
    reset_n = 1'b1;

    // 1: miss, full XIP sequence
    g0 = go_cnt; w0 = wcnt;
    apb(1'b0, 32'h3000_0010, 32'h0, rd, er, lat);
    chk("t1_data", rd, 32'hDDCCBBAA);
    chk("t1_err", {31'h0, er}, 32'h0);
    chk("t1_go", go_cnt - g0, 32'd1);
    chk("t1_mosi_hi", last_tx1, 32'h0300_0010);
    chk("t1_mosi_lo", last_tx0, 32'h0);
    chk("t1_nwrites", wcnt - w0, 32'd6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t1_wadr%0d", i), {27'h0, wlog_adr[(w0 + i) % 64]}, {27'h0, exp_adr[i]});
      chk($sformatf("t1_wdat%0d", i), wlog_dat[(w0 + i) % 64], exp_dat[i]);
    end

    // 2: cache hit
    g0 = go_cnt; s0 = stb_cycles;
    apb(1'b0, 32'h3000_0010, 32'h0, rd, er, lat);
    chk("t2_data", rd, 32'hDDCCBBAA);
    chk("t2_lat", lat, 32'd1);
    chk("t2_no_go", go_cnt - g0, 32'd0);
    chk("t2_no_wb", stb_cycles - s0, 32'd0);

    // 3: passthrough write/read, then the write has invalidated the cache
    apb(1'b1, 32'h1000_1014, 32'd5, rd, er, lat);
    chk("t3_werr", {31'h0, er}, 32'h0);
    apb(1'b0, 32'h1000_1014, 32'h0, rd, er, lat);
    chk("t3_rdback", rd, 32'd5);
    g0 = go_cnt;
    apb(1'b0, 32'h3000_0010, 32'h0, rd, er, lat);
    chk("t3_miss_go", go_cnt - g0, 32'd1);
    chk("t3_data", rd, 32'hDDCCBBAA);

    // 4: error responses without Wishbone activity
    s0 = stb_cycles;
    apb(1'b1, 32'h3000_0000, 32'h1234, rd, er, lat);
    chk("t4_flash_wr_err", {31'h0, er}, 32'h1);
    chk("t4_flash_wr_lat", lat, 32'd1);
    apb(1'b0, 32'h2000_0000, 32'h0, rd, er, lat);
    chk("t4_unmapped_err", {31'h0, er}, 32'h1);
    chk("t4_unmapped_data", rd, 32'h0);
    chk("t4_no_wb", stb_cycles - s0, 32'd0);

    // 5: 16 MiB wrap; upper bits still part of the tag
    apb(1'b0, 32'h3100_0020, 32'h0, rd, er, lat);
    chk("t5_spi_addr", last_tx1, 32'h0300_0020);
    chk("t5_data", rd, 32'hC3005A20);
    g0 = go_cnt;
    apb(1'b0, 32'h3000_0020, 32'h0, rd, er, lat);
    chk("t5_tag_miss", go_cnt - g0, 32'd1);
    chk("t5_data2", rd, 32'hC3005A20);

    // 6: reset while polling CTRL
    @(posedge clock); #1;
    in_psel = 1'b1; in_pwrite = 1'b0; in_paddr = 32'h3000_0080;
    @(posedge clock); #1;
    in_penable = 1'b1;
    n = 0;
    while (!(wb_stb_o && !wb_we_o && wb_adr_o == 5'h10) && n < 300) begin
      @(posedge clock); #1;
      n++;
    end
    chk("t6_reached_poll", {27'h0, wb_adr_o}, 32'h10);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_outputs",
        {in_pready, in_pslverr, wb_we_o, wb_stb_o, wb_cyc_o, wb_sel_o, wb_adr_o}, 32'h0);
    chk("t6_rst_prdata", in_prdata, 32'h0);
    chk("t6_rst_wbdat", wb_dat_o, 32'h0);
    in_psel = 1'b0; in_penable = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    g0 = go_cnt;
    apb(1'b0, 32'h3000_0010, 32'h0, rd, er, lat);
    chk("t6_after_data", rd, 32'hDDCCBBAA);
    chk("t6_after_go", go_cnt - g0, 32'd1);

    // 7: Wishbone error during poll gives pslverr and no cache fill
    err_poll_en = 1'b1;
    w0 = wcnt;
    apb(1'b0, 32'h3000_0040, 32'h0, rd, er, lat);
    chk("t7_err", {31'h0, er}, 32'h1);
    chk("t7_ss_off", wlog_dat[(wcnt - 1) % 64], 32'h0);
    err_poll_en = 1'b0;
    g0 = go_cnt;
    apb(1'b0, 32'h3000_0040, 32'h0, rd, er, lat);
    chk("t7_refetch", go_cnt - g0, 32'd1);
    chk("t7_data", rd, 32'hC3005A40);
    chk("t7_ok", {31'h0, er}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
